// File: rtl/cla_addsub_pipe.sv
// rtl/cla_addsub_pipe.sv - pipelined carry-lookahead two's-complement add/subtract unit
// Each stage resolves one GROUP*GPS-bit slice; carry and partial sums move stage to stage with the operands.
module cla_addsub_pipe #(
    parameter int WIDTH = 15,
    parameter int GROUP = 3,
    parameter int GPS   = 1,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    input  logic             ovf_clr,
    output logic [CNTW-1:0]  ovf_cnt
);
    localparam int SW   = GROUP * GPS;
    localparam int NSTG = WIDTH / SW;

    logic                       adv;
    logic [NSTG-1:0]            st_v;
    logic [NSTG-1:0]            st_c;
    logic [NSTG-1:0][WIDTH-1:0] st_a;
    logic [NSTG-1:0][WIDTH-1:0] st_b;
    logic [NSTG-1:0][WIDTH-1:0] st_s;
    logic [NSTG-1:0][WIDTH-1:0] s_nx;
    logic [NSTG-1:0]            c_out;
    logic [NSTG-1:0]            c_msb;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        logic [SW-1:0]    a_s;
        logic [SW-1:0]    b_s;
        logic [SW-1:0]    g;
        logic [SW-1:0]    p;
        logic [SW:0]      c;
        logic [WIDTH-1:0] ins;

        assign a_s = st_a[k][k*SW +: SW];
        assign b_s = st_b[k][k*SW +: SW];
        assign g   = a_s & b_s;
        assign p   = a_s ^ b_s;

        // Within a group every carry is a flat sum of G/P products back to the group carry-in;
        // groups inside one stage chain their carries.
        always_comb begin
            logic acc;
            logic prod;
            acc  = 1'b0;
            prod = 1'b0;
            c    = '0;
            c[0] = st_c[k];
            for (int j = 0; j < GPS; j++) begin
                for (int i = 0; i < GROUP; i++) begin
                    acc  = g[j*GROUP+i];
                    prod = p[j*GROUP+i];
                    for (int m = i - 1; m >= 0; m--) begin
                        acc  = acc | (prod & g[j*GROUP+m]);
                        prod = prod & p[j*GROUP+m];
                    end
                    acc = acc | (prod & c[j*GROUP]);
                    c[j*GROUP+i+1] = acc;
                end
            end
        end

        always_comb begin
            ins = st_s[k];
            ins[k*SW +: SW] = p ^ c[SW-1:0];
        end

        assign s_nx[k]  = ins;
        assign c_out[k] = c[SW];
        assign c_msb[k] = c[SW-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_v <= '0;
            st_c <= '0;
            st_a <= '0;
            st_b <= '0;
            st_s <= '0;
        end else if (adv) begin
            st_v[0] <= in_valid;
            st_a[0] <= A;
            st_b[0] <= B ^ {WIDTH{mode}};
            st_c[0] <= mode;
            st_s[0] <= '0;
            for (int k = 1; k < NSTG; k++) begin
                st_v[k] <= st_v[k-1];
                st_a[k] <= st_a[k-1];
                st_b[k] <= st_b[k-1];
                st_c[k] <= c_out[k-1];
                st_s[k] <= s_nx[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            S         <= '0;
            Cout      <= 1'b0;
            Ovf       <= 1'b0;
        end else if (adv) begin
            out_valid <= st_v[NSTG-1];
            if (st_v[NSTG-1]) begin
                S    <= s_nx[NSTG-1];
                Cout <= c_out[NSTG-1];
                Ovf  <= c_out[NSTG-1] ^ c_msb[NSTG-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (ovf_clr) begin
            ovf_cnt <= '0;
        end else if (out_valid && out_ready && Ovf && (ovf_cnt != {CNTW{1'b1}})) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb/tb_cla_addsub_pipe.sv - directed self-checking bench for cla_addsub_pipe
module tb_cla_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] A;
    logic [14:0] B;
    logic        mode;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] S;
    logic        Cout;
    logic        Ovf;
    logic        ovf_clr;
    logic [7:0]  ovf_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    cla_addsub_pipe #(.WIDTH(15), .GROUP(3), .GPS(1), .CNTW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .Cout(Cout), .Ovf(Ovf), .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_one(input string tag, input logic [14:0] a, input logic [14:0] b, input logic m,
                           input logic [14:0] es, input logic eco, input logic eov);
        int lat;
        A = a;
        B = b;
        mode = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, 5);
        check({tag, "_S"}, S, es);
        check({tag, "_Cout"}, Cout, eco);
        check({tag, "_Ovf"}, Ovf, eov);
        tick();
        if (eov && exp_cnt < 255) exp_cnt++;
        check({tag, "_cnt"}, ovf_cnt, exp_cnt);
    endtask

    initial begin
        int first_c;
        int last_c;
        int n_out;
        int sent;
        int n_hand;
        int wait_c;
        int stale;
        logic [14:0] got_s [10];
        logic [14:0] hold_s;
        int exp_q[$];

        rst = 1'b1;
        in_valid = 1'b0;
        A = '0;
        B = '0;
        mode = 1'b0;
        out_ready = 1'b1;
        ovf_clr = 1'b0;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_S", S, 0);
        check("rst_cnt", ovf_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        tick();

        run_one("t1a", 15'd25, 15'd50, 1'b0, 15'd75, 1'b0, 1'b0);
        run_one("t1b", 15'd8192, 15'd8192, 1'b0, 15'h4000, 1'b0, 1'b1);
        run_one("t2a", 15'h4001, 15'h4000, 1'b0, 15'h0001, 1'b1, 1'b1);
        run_one("t2b", 15'h6000, 15'h2000, 1'b1, 15'h4000, 1'b1, 1'b0);
        run_one("t3", 15'd8192, 15'h6000, 1'b1, 15'h4000, 1'b0, 1'b1);

        // Ten back-to-back operations
        n_out = 0;
        first_c = -1;
        last_c = -1;
        for (int c = 0; c < 20; c++) begin
            in_valid = (c < 10);
            A = 15'(c);
            B = 15'(c);
            mode = 1'b0;
            #1;
            if (out_valid) begin
                if (n_out < 10) got_s[n_out] = S;
                if (first_c < 0) first_c = c;
                last_c = c;
                n_out++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("t4_count", n_out, 10);
        check("t4_span", last_c - first_c + 1, 10);
        for (int i = 0; i < 10; i++) check($sformatf("t4_S%0d", i), got_s[i], 2 * i);

        // Stall with a full pipe
        sent = 0;
        n_hand = 0;
        hold_s = '0;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 7 && c < 10);
            in_valid = (sent < 8);
            A = 15'(1000 + sent);
            B = 15'(sent);
            mode = sent[0];
            #1;
            if (c == 7) begin
                check("t5_full", out_valid, 1);
                hold_s = S;
            end
            if (c >= 7 && c < 10) check($sformatf("t5_in_ready%0d", c), in_ready, 0);
            if (c == 8 || c == 9) check($sformatf("t5_hold%0d", c), S, hold_s);
            if (out_valid && out_ready) begin
                n_hand++;
                if (exp_q.size() > 0) check($sformatf("t5_S%0d", n_hand), S, exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(mode ? 1000 : 1000 + 2 * sent);
                sent++;
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("t5_handoffs", n_hand, 8);
        check("t5_left", exp_q.size(), 0);

        // Reset with operations in flight
        for (int i = 1; i <= 3; i++) begin
            A = 15'(i);
            B = 15'(i);
            mode = 1'b0;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        wait_c = 0;
        while (!out_valid && wait_c < 20) begin
            tick();
            wait_c++;
        end
        check("t6_pre", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_out_valid", out_valid, 0);
        check("t6_S", S, 0);
        check("t6_cnt", ovf_cnt, 0);
        exp_cnt = 0;
        tick();
        rst = 1'b0;
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) stale++;
            tick();
        end
        check("t6_stale", stale, 0);
        run_one("t6_after", 15'd5, 15'd6, 1'b0, 15'd11, 1'b0, 1'b0);

        // Saturation, then clear racing an overflowing handoff
        for (int c = 0; c < 320; c++) begin
            in_valid = (c < 300);
            A = 15'd8192;
            B = 15'd8192;
            mode = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        check("t6_sat", ovf_cnt, 255);
        A = 15'd8192;
        B = 15'd8192;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_c = 0;
        while (!out_valid && wait_c < 20) begin
            tick();
            wait_c++;
        end
        check("t6_clr_ovf", Ovf, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t6_clr_prio", ovf_cnt, 0);
        exp_cnt = 0;
        run_one("t6_recount", 15'd8192, 15'd8192, 1'b0, 15'h4000, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
